attention_int_sched: RTL and testbench

- Row-serial scheduler for the MX-INT attention datapath.
- Time-shares one matmul_int engine between the Q·K^T pass and the softmax·V pass.
- Sequences the external softmax/requant unit between the two passes, one Q row at a time.
- Row r flow: QK matmul, scale adjust, softmax, SMV matmul, result-row write. Sits between the host command interface and the attention datapath muxes.

---
 rtl/attention_int_sched.sv | 193 +++++++++++++++++++
 tb/tb_attention_int_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attention_int_sched.sv
// attention_int_sched
//   Row-serial scheduler for the MX-INT attention datapath. One matmul engine is
//   time-shared between the Q*K^T pass and the softmax*V pass. The external
//   softmax/requant unit runs between the two passes, one Q row at a time:
//   QK issue/wait -> scale write -> softmax issue/wait -> SMV issue/wait -> row write.
//
//   Optional feature macro: ATTN_SCHED_PERF_EN (adds o_cycles / o_stall_cycles).
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_abort        run start pulse (IDLE only), run cancel
//   o_busy                  run in progress (any state but IDLE)
//   o_done, o_aborted       one-cycle completion / cancellation pulses
//   o_eng_start             engine launch pulse
//   o_eng_op, o_eng_row     engine operand mux (0 = Q*K^T, 1 = softmax*V) and Q row
//   i_eng_done              engine result-valid pulse
//   o_scale_shift           constant $clog2(d_kq)/2
//   o_scale_we              write scaled QK row into softmax input buffer
//   o_sm_start, i_sm_done   softmax launch / completion
//   o_row_we                result row write enable for R[o_eng_row]
//   o_cycles                (perf) busy cycles, saturating
//   o_stall_cycles          (perf) cycles spent in the three WAIT states, saturating
module attention_int_sched #(
    parameter int unsigned S_q         = 4,
    parameter int unsigned d_kq        = 8,
    parameter int unsigned scale_width = 8,
    localparam int unsigned ROW_W      = (S_q > 1) ? $clog2(S_q) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_aborted,
    output logic                   o_eng_start,
    output logic                   o_eng_op,
    output logic [ROW_W-1:0]       o_eng_row,
    input  logic                   i_eng_done,
    output logic [scale_width-1:0] o_scale_shift,
    output logic                   o_scale_we,
    output logic                   o_sm_start,
    input  logic                   i_sm_done,
`ifdef ATTN_SCHED_PERF_EN
    output logic [31:0]            o_cycles,
    output logic [31:0]            o_stall_cycles,
`endif
    output logic                   o_row_we
);

    localparam int unsigned      ScaleShift = $clog2(d_kq) / 2;
    localparam logic [ROW_W-1:0] LastRow    = ROW_W'(S_q - 1);

    typedef enum logic [3:0] {
        StIdle, StQkIssue, StQkWait, StScale, StSmIssue,
        StSmWait, StSmvIssue, StSmvWait, StDone
    } state_e;

    state_e           r_state, w_state_next;
    logic [ROW_W-1:0] r_row, w_row_next;
    logic             r_eng_op, w_eng_op_next;
    logic             r_aborted;
    logic             w_run_abort;
    logic             w_eng_start, w_scale_we, w_sm_start, w_row_we, w_done;

    // Abort only applies to an active run; in IDLE a concurrent start wins.
    assign w_run_abort = i_abort && (r_state != StIdle);

    always_comb begin
        w_state_next  = r_state;
        w_row_next    = r_row;
        w_eng_op_next = r_eng_op;
        w_eng_start   = 1'b0;
        w_scale_we    = 1'b0;
        w_sm_start    = 1'b0;
        w_row_we      = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next  = StQkIssue;
                    w_row_next    = '0;
                    w_eng_op_next = 1'b0;
                end
            end
            StQkIssue: begin
                w_eng_start  = 1'b1;
                w_state_next = StQkWait;
            end
            StQkWait: begin
                if (i_eng_done) w_state_next = StScale;
            end
            StScale: begin
                w_scale_we   = 1'b1;
                w_state_next = StSmIssue;
            end
            StSmIssue: begin
                w_sm_start   = 1'b1;
                w_state_next = StSmWait;
            end
            StSmWait: begin
                if (i_sm_done) begin
                    w_state_next  = StSmvIssue;
                    w_eng_op_next = 1'b1;
                end
            end
            StSmvIssue: begin
                w_eng_start  = 1'b1;
                w_state_next = StSmvWait;
            end
            StSmvWait: begin
                if (i_eng_done) begin
                    w_row_we = 1'b1;
                    if (r_row == LastRow) begin
                        w_state_next = StDone;
                    end else begin
                        w_row_next    = r_row + ROW_W'(1);
                        w_eng_op_next = 1'b0;
                        w_state_next  = StQkIssue;
                    end
                end
            end
            StDone: begin
                w_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        // Abort overrides everything, including a done arriving in the same cycle.
        if (w_run_abort) begin
            w_state_next  = StIdle;
            w_row_next    = r_row;
            w_eng_op_next = r_eng_op;
            w_eng_start   = 1'b0;
            w_scale_we    = 1'b0;
            w_sm_start    = 1'b0;
            w_row_we      = 1'b0;
            w_done        = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_row     <= '0;
            r_eng_op  <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_row     <= w_row_next;
            r_eng_op  <= w_eng_op_next;
            r_aborted <= w_run_abort;
        end
    end

    assign o_busy        = (r_state != StIdle);
    assign o_done        = w_done;
    assign o_aborted     = r_aborted;
    assign o_eng_start   = w_eng_start;
    assign o_eng_op      = r_eng_op;
    assign o_eng_row     = r_row;
    assign o_scale_shift = scale_width'(ScaleShift);
    assign o_scale_we    = w_scale_we;
    assign o_sm_start    = w_sm_start;
    assign o_row_we      = w_row_we;

`ifdef ATTN_SCHED_PERF_EN
    logic [31:0] r_cycles, r_stall_cycles;
    logic        w_in_wait;

    assign w_in_wait = (r_state inside {StQkWait, StSmWait, StSmvWait});

    // Both counters clear on start acceptance and hold while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycles       <= '0;
            r_stall_cycles <= '0;
        end else if (r_state == StIdle) begin
            if (i_start) begin
                r_cycles       <= '0;
                r_stall_cycles <= '0;
            end
        end else begin
            if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
            if (w_in_wait && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_cycles       = r_cycles;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_attention_int_sched.sv
// Bench for attention_int_sched: three instances (S_q = 4/2/1), an automatic
// engine/softmax responder with programmable latency per instance, and directed
// scenario tasks with hand-computed expectations.
module tb_attention_int_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0] start, abort, man_eng, man_sm, auto_eng, auto_sm;
    logic [2:0] eng_done, sm_done;
    logic [2:0] busy, done, aborted, eng_start, eng_op, scale_we, sm_start, row_we;
    logic [1:0] row_a;
    logic [0:0] row_b, row_c;
    logic [7:0] shift_a, shift_b, shift_c;
`ifdef ATTN_SCHED_PERF_EN
    logic [31:0] cyc_a, stall_a, cyc_b, stall_b, cyc_c, stall_c;
`endif

    assign eng_done = auto_eng | man_eng;
    assign sm_done  = auto_sm | man_sm;

    int checks = 0;
    int errors = 0;

    attention_int_sched #(.S_q(4), .d_kq(16), .scale_width(8)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_aborted(aborted[0]),
        .o_eng_start(eng_start[0]), .o_eng_op(eng_op[0]), .o_eng_row(row_a),
        .i_eng_done(eng_done[0]), .o_scale_shift(shift_a), .o_scale_we(scale_we[0]),
        .o_sm_start(sm_start[0]), .i_sm_done(sm_done[0]),
`ifdef ATTN_SCHED_PERF_EN
        .o_cycles(cyc_a), .o_stall_cycles(stall_a),
`endif
        .o_row_we(row_we[0])
    );

    attention_int_sched #(.S_q(2), .d_kq(8), .scale_width(8)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_aborted(aborted[1]),
        .o_eng_start(eng_start[1]), .o_eng_op(eng_op[1]), .o_eng_row(row_b),
        .i_eng_done(eng_done[1]), .o_scale_shift(shift_b), .o_scale_we(scale_we[1]),
        .o_sm_start(sm_start[1]), .i_sm_done(sm_done[1]),
`ifdef ATTN_SCHED_PERF_EN
        .o_cycles(cyc_b), .o_stall_cycles(stall_b),
`endif
        .o_row_we(row_we[1])
    );

    attention_int_sched #(.S_q(1), .d_kq(64), .scale_width(8)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_abort(abort[2]),
        .o_busy(busy[2]), .o_done(done[2]), .o_aborted(aborted[2]),
        .o_eng_start(eng_start[2]), .o_eng_op(eng_op[2]), .o_eng_row(row_c),
        .i_eng_done(eng_done[2]), .o_scale_shift(shift_c), .o_scale_we(scale_we[2]),
        .o_sm_start(sm_start[2]), .i_sm_done(sm_done[2]),
`ifdef ATTN_SCHED_PERF_EN
        .o_cycles(cyc_c), .o_stall_cycles(stall_c),
`endif
        .o_row_we(row_we[2])
    );

    // Responder: done pulse N cycles after the launch pulse (N = 1 is zero-wait).
    int ed [3];
    int sd [3];
    int eng_cnt [3];
    int sm_cnt [3];
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                eng_cnt[i] <= 0; auto_eng[i] <= 1'b0;
                sm_cnt[i]  <= 0; auto_sm[i]  <= 1'b0;
            end else begin
                if (eng_start[i]) begin
                    eng_cnt[i] <= ed[i] - 1; auto_eng[i] <= (ed[i] == 1);
                end else if (eng_cnt[i] > 0) begin
                    eng_cnt[i] <= eng_cnt[i] - 1; auto_eng[i] <= (eng_cnt[i] == 1);
                end else begin
                    auto_eng[i] <= 1'b0;
                end
                if (sm_start[i]) begin
                    sm_cnt[i] <= sd[i] - 1; auto_sm[i] <= (sd[i] == 1);
                end else if (sm_cnt[i] > 0) begin
                    sm_cnt[i] <= sm_cnt[i] - 1; auto_sm[i] <= (sm_cnt[i] == 1);
                end else begin
                    auto_sm[i] <= 1'b0;
                end
            end
        end
    end

    // Record of the last watched run (cycle 0 = start-accept cycle).
    int          ob_es, ob_sm, ob_sw, ob_rw, ob_done_n, ob_abt_n, ob_done_cyc, ob_abt_cyc;
    logic [15:0] ob_ops, ob_rows;
    logic        ob_busy_after, ob_timeout;

    // Modes: 0 plain, 1 spurious dones, 2 abort in row-2 SM_WAIT, 3 start during row 1.
    task automatic watch(input int k, input int mode, input logic st_abort, input int budget);
        int c = -1;
        int tail = -1;
        logic inj_e = 1'b0, inj_s = 1'b0, inj_a = st_abort, inj_st = 1'b1;
        logic [1:0] row;
        ob_es = 0; ob_sm = 0; ob_sw = 0; ob_rw = 0; ob_done_n = 0; ob_abt_n = 0;
        ob_done_cyc = 0; ob_abt_cyc = 0; ob_ops = '0; ob_rows = '0;
        ob_busy_after = 1'b1; ob_timeout = 1'b0;
        while (c < budget && tail != 0) begin
            @(negedge clk);
            man_eng[k] = inj_e; man_sm[k] = inj_s; abort[k] = inj_a; start[k] = inj_st;
            inj_e = 1'b0; inj_s = 1'b0; inj_a = 1'b0; inj_st = 1'b0;
            #1;
            c++;
            if (tail > 0) tail--;
            case (k)
                0:       row = row_a;
                1:       row = {1'b0, row_b};
                default: row = {1'b0, row_c};
            endcase
            if (eng_start[k]) begin
                ob_ops = {ob_ops[14:0], eng_op[k]};
                ob_es++;
                if (mode == 1 && !eng_op[k] && ob_es == 3) inj_s = 1'b1;
                if (mode == 3 && ob_es == 3) inj_st = 1'b1;
            end
            if (sm_start[k]) begin
                ob_sm++;
                if (mode == 1 && ob_sm == 2) inj_e = 1'b1;
                if (mode == 2 && ob_sm == 3) inj_a = 1'b1;
            end
            if (scale_we[k]) ob_sw++;
            if (row_we[k]) begin
                ob_rows = {ob_rows[13:0], row};
                ob_rw++;
            end
            if (ob_done_cyc > 0 && c == ob_done_cyc + 1) ob_busy_after = busy[k];
            if (done[k]) begin
                ob_done_n++;
                if (tail < 0) begin ob_done_cyc = c; tail = 12; end
            end
            if (aborted[k]) begin
                ob_abt_n++;
                if (tail < 0) begin ob_abt_cyc = c; tail = 12; ob_busy_after = busy[k]; end
            end
        end
        if (tail != 0) ob_timeout = 1'b1;
        man_eng[k] = 1'b0; man_sm[k] = 1'b0; abort[k] = 1'b0; start[k] = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({busy, done, aborted, eng_start, eng_op, scale_we, sm_start, row_we} !== '0)
            begin errors++; $display("FAIL reset_outputs got %0h want 0",
            {busy, done, aborted, eng_start, eng_op, scale_we, sm_start, row_we}); end
        checks++; if ({row_a, row_b, row_c} !== 4'd0)
            begin errors++; $display("FAIL reset_rows got %0h want 0", {row_a, row_b, row_c}); end
        checks++; if (shift_a !== 8'd2)
            begin errors++; $display("FAIL shift_dkq16 got %0d want 2", shift_a); end
        checks++; if (shift_b !== 8'd1)
            begin errors++; $display("FAIL shift_dkq8 got %0d want 1", shift_b); end
        checks++; if (shift_c !== 8'd3)
            begin errors++; $display("FAIL shift_dkq64 got %0d want 3", shift_c); end
`ifdef ATTN_SCHED_PERF_EN
        checks++; if ({cyc_a, stall_a, cyc_b, stall_b, cyc_c, stall_c} !== '0)
            begin errors++; $display("FAIL reset_perf got nonzero want 0"); end
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        ed[0] = 3; sd[0] = 2;
        watch(0, 0, 1'b0, 100);
        checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL nom_timeout got 1 want 0"); end
        checks++; if (ob_es !== 8) begin errors++; $display("FAIL nom_eng_starts got %0d want 8", ob_es); end
        checks++; if (ob_ops[7:0] !== 8'h55)
            begin errors++; $display("FAIL nom_op_seq got %0h want 55", ob_ops[7:0]); end
        checks++; if (ob_sw !== 4) begin errors++; $display("FAIL nom_scale_we got %0d want 4", ob_sw); end
        checks++; if (ob_rw !== 4) begin errors++; $display("FAIL nom_row_we got %0d want 4", ob_rw); end
        checks++; if (ob_rows[7:0] !== 8'h1B)
            begin errors++; $display("FAIL nom_rows got %0h want 1b", ob_rows[7:0]); end
        checks++; if (ob_done_n !== 1) begin errors++; $display("FAIL nom_done_n got %0d want 1", ob_done_n); end
        checks++; if (ob_done_cyc !== 49)
            begin errors++; $display("FAIL nom_done_cycle got %0d want 49", ob_done_cyc); end
        checks++; if (ob_busy_after !== 1'b0)
            begin errors++; $display("FAIL nom_busy_after got %0b want 0", ob_busy_after); end
    endtask

    task automatic test_zero_wait();
        ed[0] = 1; sd[0] = 1;
        watch(0, 0, 1'b0, 80);
        checks++; if (ob_done_cyc !== 29)
            begin errors++; $display("FAIL zw_done_cycle got %0d want 29", ob_done_cyc); end
        checks++; if (ob_rows[7:0] !== 8'h1B || ob_rw !== 4)
            begin errors++; $display("FAIL zw_rows got %0h/%0d want 1b/4", ob_rows[7:0], ob_rw); end
    endtask

    task automatic test_spurious();
        ed[0] = 3; sd[0] = 2;
        watch(0, 1, 1'b0, 100);
        checks++; if (ob_done_cyc !== 49)
            begin errors++; $display("FAIL spur_done_cycle got %0d want 49", ob_done_cyc); end
        checks++; if (ob_rw !== 4 || ob_rows[7:0] !== 8'h1B)
            begin errors++; $display("FAIL spur_rows got %0h/%0d want 1b/4", ob_rows[7:0], ob_rw); end
        checks++; if (ob_es !== 8) begin errors++; $display("FAIL spur_eng_starts got %0d want 8", ob_es); end
    endtask

    task automatic test_abort();
        ed[0] = 3; sd[0] = 2;
        watch(0, 2, 1'b0, 100);
        checks++; if (ob_abt_cyc !== 32)
            begin errors++; $display("FAIL abort_cycle got %0d want 32", ob_abt_cyc); end
        checks++; if (ob_abt_n !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", ob_abt_n); end
        checks++; if (ob_busy_after !== 1'b0)
            begin errors++; $display("FAIL abort_busy got %0b want 0", ob_busy_after); end
        checks++; if (ob_done_n !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", ob_done_n); end
        checks++; if (ob_es !== 5) begin errors++; $display("FAIL abort_eng_starts got %0d want 5", ob_es); end
        checks++; if (ob_rw !== 2 || ob_rows[3:0] !== 4'b0001)
            begin errors++; $display("FAIL abort_rows got %0h/%0d want 1/2", ob_rows[3:0], ob_rw); end
    endtask

    task automatic test_start_while_busy();
        ed[0] = 1; sd[0] = 1;
        watch(0, 3, 1'b0, 80);
        checks++; if (ob_done_n !== 1) begin errors++; $display("FAIL sbusy_done_n got %0d want 1", ob_done_n); end
        checks++; if (ob_done_cyc !== 29)
            begin errors++; $display("FAIL sbusy_done_cycle got %0d want 29", ob_done_cyc); end
        checks++; if (ob_es !== 8) begin errors++; $display("FAIL sbusy_eng_starts got %0d want 8", ob_es); end
    endtask

    task automatic test_reset_mid_run();
        logic hit = 1'b0;
        ed[0] = 3; sd[0] = 2;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        for (int c = 1; c < 60; c++) begin
            #1;
            if (eng_start[0] && eng_op[0]) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_reach_smv got 0 want 1"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy[0], done[0], aborted[0], eng_start[0], eng_op[0], scale_we[0],
                      sm_start[0], row_we[0], row_a} !== 10'd0)
            begin errors++; $display("FAIL rst_mid_outputs got %0h want 0", {busy[0], done[0],
            aborted[0], eng_start[0], eng_op[0], scale_we[0], sm_start[0], row_we[0], row_a}); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({busy[0], done[0], aborted[0], row_we[0]} !== 4'd0)
            begin errors++; $display("FAIL rst_hold_outputs got %0h want 0",
            {busy[0], done[0], aborted[0], row_we[0]}); end
        @(negedge clk);
        rst_n = 1'b1;
        ed[0] = 1; sd[0] = 1;
        watch(0, 0, 1'b0, 80);
        checks++; if (ob_done_cyc !== 29 || ob_rows[7:0] !== 8'h1B)
            begin errors++; $display("FAIL rst_rerun got %0d/%0h want 29/1b", ob_done_cyc, ob_rows[7:0]); end
    endtask

    task automatic test_two_rows();
        ed[1] = 1; sd[1] = 1;
        for (int run = 0; run < 2; run++) begin
            watch(1, 0, 1'b0, 60);
            checks++; if (ob_done_cyc !== 15)
                begin errors++; $display("FAIL two_done_cycle got %0d want 15", ob_done_cyc); end
            checks++; if (ob_ops[3:0] !== 4'b0101 || ob_rows[3:0] !== 4'b0001)
                begin errors++; $display("FAIL two_ops_rows got %0h/%0h want 5/1", ob_ops[3:0], ob_rows[3:0]); end
`ifdef ATTN_SCHED_PERF_EN
            checks++; if (cyc_b !== 32'd15)
                begin errors++; $display("FAIL perf_cycles got %0d want 15", cyc_b); end
            checks++; if (stall_b !== 32'd6)
                begin errors++; $display("FAIL perf_stall got %0d want 6", stall_b); end
`endif
        end
    endtask

    task automatic test_single_row();
        ed[2] = 1; sd[2] = 1;
        @(negedge clk); abort[2] = 1'b1;
        @(negedge clk); abort[2] = 1'b0;
        #1;
        checks++; if ({aborted[2], busy[2]} !== 2'b00)
            begin errors++; $display("FAIL idle_abort got %0b want 00", {aborted[2], busy[2]}); end
        watch(2, 0, 1'b1, 40);
        checks++; if (ob_done_cyc !== 8 || ob_abt_n !== 0)
            begin errors++; $display("FAIL one_done got %0d/%0d want 8/0", ob_done_cyc, ob_abt_n); end
        checks++; if (ob_es !== 2 || ob_ops[1:0] !== 2'b01)
            begin errors++; $display("FAIL one_eng got %0d/%0b want 2/01", ob_es, ob_ops[1:0]); end
        checks++; if (ob_rw !== 1 || ob_rows[1:0] !== 2'd0)
            begin errors++; $display("FAIL one_rows got %0d/%0d want 1/0", ob_rw, ob_rows[1:0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0; abort = '0; man_eng = '0; man_sm = '0;
        for (int i = 0; i < 3; i++) begin ed[i] = 1; sd[i] = 1; end
        test_reset();
        test_nominal();
        test_zero_wait();
        test_spurious();
        test_abort();
        test_start_while_busy();
        test_reset_mid_run();
        test_two_rows();
        test_single_row();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
